// File: rtl/rom_arbiter.sv
// Round-robin arbiter and burst sequencer for a shared combinational ROM.
// Grants one of two requesters, walks the ROM address once per clock and returns registered words.
module rom_arbiter #(
   parameter int AW = 7,
   parameter int DW = 13,
   parameter int LW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [LW-1:0] len0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [LW-1:0] len1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          vld0,
   output logic          vld1,
   output logic          last,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data
);

   // Handshake: reqN stays high until gntN pulses; addrN/lenN are captured on that same edge only.
   typedef enum logic {IDLE, READ} state_t;

   state_t        state, state_n;
   logic          owner, owner_n;
   logic          prio, prio_n;
   logic [AW-1:0] cur_addr, cur_addr_n;
   logic [LW-1:0] count, count_n;
   logic          gnt0_n, gnt1_n, vld0_n, vld1_n, last_n, busy_n;
   logic [DW-1:0] rdata_n;
   logic          winner;

   assign rom_addr = cur_addr;

   always_comb begin
      state_n    = state;
      owner_n    = owner;
      prio_n     = prio;
      cur_addr_n = cur_addr;
      count_n    = count;
      rdata_n    = rdata;
      gnt0_n     = 1'b0;
      gnt1_n     = 1'b0;
      vld0_n     = 1'b0;
      vld1_n     = 1'b0;
      last_n     = 1'b0;
      busy_n     = 1'b0;
      // prio only matters on a tie; a lone requester always wins
      winner     = (req0 && req1) ? prio : req1;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_n    = winner;
               cur_addr_n = winner ? addr1 : addr0;
               count_n    = winner ? len1 : len0;
               gnt0_n     = ~winner;
               gnt1_n     = winner;
               busy_n     = 1'b1;
               state_n    = READ;
            end
         end
         READ: begin
            rdata_n    = rom_data;
            vld0_n     = ~owner;
            vld1_n     = owner;
            busy_n     = 1'b1;
            cur_addr_n = cur_addr + AW'(1);
            if (count == '0) begin
               last_n  = 1'b1;
               prio_n  = ~owner;
               state_n = IDLE;
            end else begin
               count_n = count - LW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         prio     <= 1'b0;
         cur_addr <= '0;
         count    <= '0;
         rdata    <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         vld0     <= 1'b0;
         vld1     <= 1'b0;
         last     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         prio     <= prio_n;
         cur_addr <= cur_addr_n;
         count    <= count_n;
         rdata    <= rdata_n;
         gnt0     <= gnt0_n;
         gnt1     <= gnt1_n;
         vld0     <= vld0_n;
         vld1     <= vld1_n;
         last     <= last_n;
         busy     <= busy_n;
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: ROM model returns address+100, expected words are queued at request time
// and compared as vld strobes appear.
module tb_rom_arbiter;
   localparam int AW = 7;
   localparam int DW = 13;
   localparam int LW = 3;
   localparam int W  = DW + 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic [LW-1:0] len0, len1;
   logic          gnt0, gnt1, vld0, vld1, last, busy;
   logic [DW-1:0] rdata;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   always #5 clk = ~clk;

   assign rom_data = DW'(rom_addr) + DW'(100);

   rom_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .len0(len0),
      .req1(req1), .addr1(addr1), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
      .last(last), .rdata(rdata), .busy(busy),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard entry: {vld1, vld0, last, rdata}
   task automatic push_burst(input logic who, input logic [AW-1:0] addr, input int len, input int n);
      logic [AW-1:0] a;
      for (int k = 0; k < n; k++) begin
         a = addr + AW'(k);
         exp_q.push_back({who, ~who, (k == len), DW'(a) + DW'(100)});
      end
   endtask

   always @(negedge clk) begin
      if (vld0 || vld1) begin
         if (exp_q.size() == 0) begin
            check("spurious_vld", 32'({vld1, vld0}), 32'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("word", 32'({vld1, vld0, last, rdata}), 32'(mon_e));
         end
      end else if (last) begin
         check("last_without_vld", 32'(last), 32'(0));
      end
   end

   task automatic wait_gnt(input logic who, output int n);
      logic got;
      got = 1'b0;
      n = 0;
      while (!got && n < 50) begin
         @(negedge clk);
         n++;
         got = who ? gnt1 : gnt0;
      end
      if (!got) check("gnt_timeout", 32'(got), 32'(1));
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
      end
      check("idle_timeout", 32'(i < 100), 32'(1));
   endtask

   task automatic dual_round(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      int n;
      push_burst(1'b0, a0, 1, 2);
      push_burst(1'b1, a1, 1, 2);
      addr0 = a0; len0 = 3'd1; addr1 = a1; len1 = 3'd1;
      req0 = 1'b1; req1 = 1'b1;
      wait_gnt(1'b0, n);
      check("dual_gnt0_lat", 32'(n), 32'(1));
      check("dual_gnt1_low", 32'(gnt1), 32'(0));
      req0 = 1'b0;
      wait_gnt(1'b1, n);
      check("dual_gnt1_gap", 32'(n), 32'(3));
      check("dual_rom_addr1", 32'(rom_addr), 32'(a1));
      req1 = 1'b0;
      wait_idle();
   endtask

   initial begin
      int n;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt0", 32'(gnt0), 32'(0));
      check("rst_gnt1", 32'(gnt1), 32'(0));
      check("rst_vld", 32'({vld1, vld0}), 32'(0));
      check("rst_last", 32'(last), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_rdata", 32'(rdata), 32'(0));
      check("rst_rom_addr", 32'(rom_addr), 32'(0));
      reset = 1'b0;

      // single-word burst, exact cycle timing
      push_burst(1'b0, 7'd5, 0, 1);
      addr0 = 7'd5; len0 = 3'd0; req0 = 1'b1;
      wait_gnt(1'b0, n);
      check("t1_gnt_lat", 32'(n), 32'(1));
      check("t1_gnt1", 32'(gnt1), 32'(0));
      check("t1_busy_c0", 32'(busy), 32'(1));
      check("t1_rom_addr", 32'(rom_addr), 32'(5));
      check("t1_vld_c0", 32'({vld1, vld0}), 32'(0));
      req0 = 1'b0;
      @(negedge clk);
      check("t1_vld0_c1", 32'(vld0), 32'(1));
      check("t1_last_c1", 32'(last), 32'(1));
      check("t1_rdata_c1", 32'(rdata), 32'(105));
      @(negedge clk);
      check("t1_busy_c2", 32'(busy), 32'(0));
      check("t1_vld_c2", 32'({vld1, vld0, last}), 32'(0));

      // requester 1 burst wrapping past the top of the ROM
      push_burst(1'b1, 7'd126, 3, 4);
      addr1 = 7'd126; len1 = 3'd3; req1 = 1'b1;
      wait_gnt(1'b1, n);
      check("t2_rom_addr", 32'(rom_addr), 32'(126));
      req1 = 1'b0;
      wait_idle();

      // dual requests from reset release alternate 0,1 then 0,1 again
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dual_round(7'd20, 7'd30);
      dual_round(7'd60, 7'd90);

      // req1 arrives mid-burst and waits; addr0/len0 changes after acceptance are ignored
      push_burst(1'b0, 7'd10, 7, 8);
      push_burst(1'b1, 7'd50, 0, 1);
      addr0 = 7'd10; len0 = 3'd7; req0 = 1'b1;
      wait_gnt(1'b0, n);
      req0 = 1'b0; addr0 = 7'd99; len0 = 3'd0;
      addr1 = 7'd50; len1 = 3'd0; req1 = 1'b1;
      wait_gnt(1'b1, n);
      check("t4_gnt1_gap", 32'(n), 32'(9));
      check("t4_no_overlap", 32'({vld1, vld0}), 32'(0));
      req1 = 1'b0;
      wait_idle();

      // reset in the middle of an 8-word burst
      push_burst(1'b0, 7'd0, 7, 3);
      addr0 = 7'd0; len0 = 3'd7; req0 = 1'b1;
      wait_gnt(1'b0, n);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_gnt", 32'({gnt1, gnt0}), 32'(0));
      check("t5_rst_vld", 32'({vld1, vld0, last}), 32'(0));
      check("t5_rst_busy", 32'(busy), 32'(0));
      check("t5_rst_rdata", 32'(rdata), 32'(0));
      check("t5_rst_rom_addr", 32'(rom_addr), 32'(0));
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_abandoned", 32'(exp_q.size()), 32'(0));
      check("t5_busy_after", 32'(busy), 32'(0));
      push_burst(1'b0, 7'd40, 0, 1);
      addr0 = 7'd40; len0 = 3'd0; req0 = 1'b1;
      wait_gnt(1'b0, n);
      check("t5_new_gnt_lat", 32'(n), 32'(1));
      req0 = 1'b0;
      wait_idle();

      // random bursts from a single requester at a time
      for (int r = 0; r < 6; r++) begin
         logic          who;
         logic [AW-1:0] a;
         logic [LW-1:0] l;
         who = 1'($urandom_range(0, 1));
         a   = AW'($urandom_range(0, 127));
         l   = LW'($urandom_range(0, 7));
         push_burst(who, a, int'(l), int'(l) + 1);
         if (who) begin addr1 = a; len1 = l; req1 = 1'b1; end
         else     begin addr0 = a; len0 = l; req0 = 1'b1; end
         wait_gnt(who, n);
         check("rnd_rom_addr", 32'(rom_addr), 32'(a));
         req0 = 1'b0; req1 = 1'b0;
         wait_idle();
      end

      repeat (2) @(negedge clk);
      check("q_empty", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin read arbiter and burst sequencer for the shared 128×13 combinational ROM (7-bit address, 13-bit data). Two requesters each issue a start address and burst length. The block grants one requester at a time, steps the ROM address once per clock with wrap-around, and returns registered data words with per-requester valid strobes. It sits between the ROM and its two consumers and is the only driver of the ROM address bus.

## Interface
- AW, 7, ROM address width
- DW, 13, ROM data width
- LW, 3, burst length field width; burst = len+1 words (1..8)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req0  in  1  requester 0 read request; held high until gnt0
- addr0  in  AW  requester 0 start address
- len0  in  LW  requester 0 burst length minus one
- req1, addr1, len1  in  1/AW/LW  same for requester 1
- gnt0, gnt1  out  1  one-cycle acceptance pulse
- vld0, vld1  out  1  rdata valid for requester 0/1
- last  out  1  final word of current burst (coincides with vld)
- rdata  out  DW  registered ROM word
- busy  out  1  burst in progress
- rom_addr  out  AW  address to ROM
- rom_data  in  DW  combinational ROM output

## Operation
- FSM states: IDLE, READ. Registers: state, owner, prio, cur_addr, count, plus all outputs.
- All outputs are registered. Reset value of every output is 0, state is IDLE, and prio is 0.
- IDLE, no req: hold. gnt/vld/last are 0.
- IDLE, any req: the winner is the only requester, or prio when both request. On that edge:
  - owner <= winner; cur_addr <= addr_w; count <= len_w
  - gnt_w <= 1 (one cycle); busy <= 1; state <= READ
- rom_addr always equals cur_addr.
- READ, each edge:
  - rdata <= rom_data; vld_owner <= 1
  - cur_addr <= cur_addr+1, modulo 2^AW (127 -> 0)
  - If count == 0: last <= 1; state <= IDLE; prio <= ~owner. Otherwise count <= count-1.
- Edge after last: busy, vld, and last all return to 0.
- Requests are sampled only in IDLE. A req arriving during READ waits. addr/len are sampled only at acceptance; later changes are ignored.
- vld for the non-owner is never asserted.
- Reset mid-burst: on the next edge all outputs are 0, state is IDLE, prio is 0, and the burst is abandoned. It does not resume after reset releases.

## Timing
- E0 = acceptance edge; Ck = cycle after edge Ek.
- C0: gnt high, busy high, rom_addr = start address.
- Word k (k = 0..len) appears on rdata/vld in cycle Ck+1. First-data latency is 2 edges from req sampling.
- Burst of L words: vld is high for L consecutive cycles C1..CL; last is high in CL only.
- Earliest next gnt is CL+1. The bus always has one idle cycle between bursts.
- Simultaneous req0/req1 in IDLE: prio wins. prio toggles after each completed burst, so continuous dual requests alternate 0,1,0,1.

## Test plan
Bench ROM model: rom_data = rom_addr + 100.
- Reset held 2 cycles -> gnt0/1, vld0/1, last, busy, rdata, rom_addr all 0.
- req0, addr0=5, len0=0 -> gnt0 in C0; vld0=1, last=1, rdata=105 in C1; busy=0 in C2.
- req1, addr1=126, len1=3 -> vld1 for 4 cycles with rdata 226, 227, 100, 101; last on the 4th; vld0 stays 0.
- req0 and req1 both held from reset release, len=1 each -> gnt0 first with rdata 2 words; gnt1 in the cycle after last; next simultaneous round grants 0 again.
- req1 raised during a req0 burst (addr0=10, len0=7) -> 8 vld0 words 110..117; gnt1 exactly one cycle after last; no overlap.
- Burst addr0=0, len0=7; reset asserted after the 3rd vld0 -> next cycle all outputs 0; no further vld after release; a new req0, addr0=40, len0=0 returns 140.
